uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with UART_TX: recovers 8-bit bytes from the Serial_Data line (8N1, LSB first)
//  and presents each byte to the downstream audio sink with a one-cycle valid strobe. Sits at the far
//  end of the serial link; in loopback benches it connects directly to UART_TX Serial_Data.
// PARAMETERS
//  CLKS_PER_BIT  434  CLOCK_50 cycles per bit (50 MHz / 115200); must be >= 8
//  HALF_BIT      CLKS_PER_BIT/2  cycles from detected start edge to mid-start-bit sample
// PORTS
//  CLOCK_50        in   1  system clock, 50 MHz, all logic on rising edge
//  Reset           in   1  asynchronous, active-high reset
//  Serial_Data     in   1  asynchronous serial line, idle high
//  Output_Data     out  8  last correctly framed byte
//  Data_Valid      out  1  one-cycle pulse: Output_Data updated this cycle
//  Framing_Error   out  1  one-cycle pulse: stop bit sampled low
//  Busy            out  1  high whenever State != IDLE
//  State           out  2  debug: IDLE=00 START=01 DATA=10 STOP=11
// BEHAVIOUR
//  - One clock (CLOCK_50); Reset asynchronous, active-high. Reset values: Output_Data=0, Data_Valid=0,
//    Framing_Error=0, Busy=0, State=IDLE, bit/cycle counters=0, shift reg=0, both sync flops=1.
//  - Serial_Data passes a 2-flop synchroniser (reset to 1); all decisions use synchronised value rx_s.
//  - Start detect = falling edge of rx_s (prev 1, now 0). A line held low never retriggers.
//  - IDLE: on start detect -> START, cycle counter=0.
//  - START: count cycles; when counter == HALF_BIT-1 sample rx_s: 0 -> DATA (counter=0, bit=0);
//    1 -> glitch, back to IDLE, no outputs pulsed.
//  - DATA: when counter == CLKS_PER_BIT-1 sample rx_s into shift reg MSB, shift right (LSB first),
//    counter=0, bit++; after 8th sample -> STOP.
//  - STOP: when counter == CLKS_PER_BIT-1 sample rx_s: 1 -> Output_Data<=shift, Data_Valid=1 for
//    exactly one cycle; 0 -> Framing_Error=1 for one cycle, Output_Data unchanged. Either way -> IDLE.
//  - Latency: Data_Valid asserts HALF_BIT + 9*CLKS_PER_BIT cycles after start edge seen on rx_s
//    (= pin edge + 2 sync cycles), +/-1 cycle.
//  - Back-to-back frames: IDLE entered at mid-stop-bit, so a start bit immediately following the
//    stop bit (zero idle gap) is caught; no frame loss.
//  - Data_Valid and Framing_Error never assert in the same cycle; no acknowledge, consumer must
//    capture on the strobe. Output_Data holds until next good frame.
//  - Reset mid-frame: immediate return to IDLE, partial byte discarded, no strobes.
//  - Counters sized $clog2(CLKS_PER_BIT); bit counter 4 bits; no wrap beyond terminal counts.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; after 8th data bit DATA samples a 9th (parity) bit
//    one CLKS_PER_BIT later, then STOP. Extra port Parity_Error out 1: one-cycle pulse at stop
//    sample when parity bit != XOR of data bits; on parity error Data_Valid is suppressed and
//    Output_Data unchanged (framing error takes priority if both). Latency becomes
//    HALF_BIT + 10*CLKS_PER_BIT. State encoding unchanged.
//  Undefined: 8N1 as above; Parity_Error port absent.
// TESTING (CLKS_PER_BIT=16 for all benches)
//  1 Reset pulse, then frame 0x41 (bits 1,0,0,0,0,0,1,0 LSB first), stop=1 -> Output_Data=0x41,
//    Data_Valid high exactly one cycle ~152 cycles after start edge, Framing_Error=0, State back to 00.
//  2 Line low for 4 cycles then high -> State goes 01 then 00, no Data_Valid/Framing_Error,
//    Output_Data unchanged.
//  3 Frame 0x41 then frame 0x7E with stop bit driven low -> Framing_Error one-cycle pulse,
//    Output_Data stays 0x41, Data_Valid not asserted for second frame.
//  4 Frames 0x55 and 0xAA with zero idle gap -> two Data_Valid pulses, Output_Data 0x55 then 0xAA.
//  5 Reset asserted during data bit 3 of frame 0xFF -> all outputs 0 immediately, State=00;
//    after release, frame 0x0F -> Output_Data=0x0F, one Data_Valid.
//  6 UART_RX_PARITY_EN: 0x41 with parity 0 -> Data_Valid, Output_Data=0x41; 0x41 with parity 1 ->
//    Parity_Error pulse, no Data_Valid, Output_Data unchanged.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line and the receiver's result/status
// signals so that the receiver and whatever sits around it share one port.
// When UART_RX_PARITY_EN is defined, the Parity_Error strobe is added.
interface uart_rx_if;
  logic       Serial_Data;
  logic [7:0] Output_Data;
  logic       Data_Valid;
  logic       Framing_Error;
  logic       Busy;
  logic [1:0] State;
`ifdef UART_RX_PARITY_EN
  logic       Parity_Error;
`endif

  // master: the side that drives the serial line and consumes received bytes
  modport master (
    output Serial_Data,
    input  Output_Data,
    input  Data_Valid,
    input  Framing_Error,
`ifdef UART_RX_PARITY_EN
    input  Parity_Error,
`endif
    input  Busy,
    input  State
  );

  // slave: the receiver itself
  modport slave (
    input  Serial_Data,
    output Output_Data,
    output Data_Valid,
    output Framing_Error,
`ifdef UART_RX_PARITY_EN
    output Parity_Error,
`endif
    output Busy,
    output State
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1, LSB first. It oversamples by counting
// CLOCK_50 cycles and samples each bit in the middle of its bit period.
// Every good byte is presented with a one-cycle Data_Valid strobe. If the
// stop bit is sampled low, a one-cycle Framing_Error strobe is raised instead.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and adds a
// Parity_Error strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic     CLOCK_50,
  input logic     Reset,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta, rx_s, rx_prev;
  logic             start_edge;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle-high reset
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.Serial_Data;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;

  // State, counters, shift register and registered output strobes
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state and datapath decisions; strobes default low so they last one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q < 4'd8) shift_d = {rx_s, shift_q[7:1]};
          else              par_d   = rx_s;
`else
          shift_d = {rx_s, shift_q[7:1]};
`endif
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != ^shift_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Output_Data   = data_q;
  assign bus.Data_Valid    = valid_q;
  assign bus.Framing_Error = ferr_q;
  assign bus.Busy          = (state_q != IDLE);
  assign bus.State         = state_q;
`ifdef UART_RX_PARITY_EN
  assign bus.Parity_Error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT=16.
// Frames are driven on the pin. The expected bytes and strobe counts come
// from a simple frame-level model: a good stop bit (and good parity, when
// parity is enabled) means the byte is delivered.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_rx_if bus();

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .CLOCK_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int both_cnt  = 0;
  int valid_cyc = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_last = 8'h00;
`ifdef UART_RX_PARITY_EN
  int   perr_cnt = 0;
  logic par_flip = 1'b0;
`endif

  // Collect strobes and delivered bytes away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (bus.Data_Valid === 1'b1) begin
      rx_q.push_back(bus.Output_Data);
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (bus.Framing_Error === 1'b1) ferr_cnt++;
    if (bus.Data_Valid === 1'b1 && bus.Framing_Error === 1'b1) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (bus.Parity_Error === 1'b1) perr_cnt++;
    if (bus.Data_Valid === 1'b1 && bus.Parity_Error === 1'b1) both_cnt++;
`endif
  end

  task automatic drive_bit(input logic v);
    bus.Serial_Data = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.Serial_Data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic test_reset();
    bus.Serial_Data = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.Output_Data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.Output_Data); end
    total++; if (bus.Data_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.Data_Valid); end
    total++; if (bus.Framing_Error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", bus.Framing_Error); end
    total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Busy); end
    total++; if (bus.State !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", bus.State); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_good_frame();
    int v0, s, lat;
    v0 = valid_cnt;
    rx_q.delete();
    send_frame(8'h41, 1'b1, s);
    idle(10);
    exp_last = 8'h41;
    lat = valid_cyc - s;
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL good_valid_count got=%0d want=1", valid_cnt - v0); end
    total++; if (bus.Output_Data !== 8'h41) begin bad++; $display("FAIL good_data got=%h want=41", bus.Output_Data); end
    total++; if (lat < 152 || lat > 158) begin bad++; $display("FAIL good_latency got=%0d want=152..158", lat); end
    total++; if (ferr_cnt !== 0) begin bad++; $display("FAIL good_ferr got=%0d want=0", ferr_cnt); end
    total++; if (bus.State !== 2'b00) begin bad++; $display("FAIL good_state got=%b want=00", bus.State); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    logic saw_start;
    v0 = valid_cnt; f0 = ferr_cnt;
    saw_start = 1'b0;
    bus.Serial_Data = 1'b0;
    repeat (4) @(negedge clk);
    bus.Serial_Data = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.State === 2'b01) saw_start = 1'b1;
    end
    total++; if (saw_start !== 1'b1) begin bad++; $display("FAIL glitch_start_seen got=%b want=1", saw_start); end
    total++; if (bus.State !== 2'b00) begin bad++; $display("FAIL glitch_state got=%b want=00", bus.State); end
    total++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_strobes got=%0d/%0d want=0/0", valid_cnt - v0, ferr_cnt - f0); end
    total++; if (bus.Output_Data !== exp_last) begin bad++; $display("FAIL glitch_data got=%h want=%h", bus.Output_Data, exp_last); end
  endtask

  task automatic test_framing_error();
    int v0, f0, s;
    send_frame(8'h41, 1'b1, s);
    idle(5);
    exp_last = 8'h41;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h7E, 1'b0, s);
    idle(20);
    total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_pulse got=%0d want=1", ferr_cnt - f0); end
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL ferr_no_valid got=%0d want=0", valid_cnt - v0); end
    total++; if (bus.Output_Data !== exp_last) begin bad++; $display("FAIL ferr_data got=%h want=%h", bus.Output_Data, exp_last); end
  endtask

  task automatic test_back_to_back();
    int v0, s;
    logic [7:0] got;
    rx_q.delete();
    v0 = valid_cnt;
    send_frame(8'h55, 1'b1, s);
    send_frame(8'hAA, 1'b1, s);
    idle(10);
    exp_last = 8'hAA;
    total++; if (valid_cnt - v0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", valid_cnt - v0); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    total++; if (got !== 8'h55) begin bad++; $display("FAIL b2b_first got=%h want=55", got); end
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    total++; if (got !== 8'hAA) begin bad++; $display("FAIL b2b_second got=%h want=aa", got); end
  endtask

  task automatic test_reset_midframe();
    int v0, s;
    logic [7:0] b;
    b = 8'hFF;
    v0 = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    repeat (HALF) @(negedge clk);
    total++; if (bus.Busy !== 1'b1 || bus.State !== 2'b10) begin bad++; $display("FAIL mid_busy got=%b/%b want=1/10", bus.Busy, bus.State); end
    rst = 1'b1;
    #1;
    total++; if (bus.Output_Data !== 8'h00 || bus.Busy !== 1'b0 || bus.State !== 2'b00) begin bad++; $display("FAIL mid_reset got=%h/%b/%b want=00/0/00", bus.Output_Data, bus.Busy, bus.State); end
    @(negedge clk);
    bus.Serial_Data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL mid_no_strobe got=%0d want=0", valid_cnt - v0); end
    send_frame(8'h0F, 1'b1, s);
    idle(10);
    exp_last = 8'h0F;
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", valid_cnt - v0); end
    total++; if (bus.Output_Data !== 8'h0F) begin bad++; $display("FAIL mid_after_data got=%h want=0f", bus.Output_Data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0, s;
    v0 = valid_cnt; p0 = perr_cnt;
    par_flip = 1'b0;
    send_frame(8'h41, 1'b1, s);
    idle(5);
    exp_last = 8'h41;
    total++; if (valid_cnt - v0 !== 1 || bus.Output_Data !== 8'h41) begin bad++; $display("FAIL par_good got=%0d/%h want=1/41", valid_cnt - v0, bus.Output_Data); end
    par_flip = 1'b1;
    send_frame(8'h41, 1'b1, s);
    idle(5);
    par_flip = 1'b0;
    total++; if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL par_error got=%0d want=1", perr_cnt - p0); end
    total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL par_no_valid got=%0d want=1", valid_cnt - v0); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b, got;
    logic stop_bit, prev_bad;
    int v0, f0, exp_ferr, s, gap;
`ifdef UART_RX_PARITY_EN
    int p0, exp_perr;
    p0 = perr_cnt; exp_perr = 0;
`endif
    rx_q.delete();
    v0 = valid_cnt; f0 = ferr_cnt; exp_ferr = 0;
    prev_bad = 1'b0;
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      gap = prev_bad ? $urandom_range(3, 20) : $urandom_range(0, 20);
      if (gap > 0) idle(gap);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 3) == 0);
`endif
      send_frame(b, stop_bit, s);
      if (!stop_bit) exp_ferr++;
`ifdef UART_RX_PARITY_EN
      else if (par_flip) exp_perr++;
`endif
      else begin exp_q.push_back(b); exp_last = b; end
      prev_bad = !stop_bit;
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    idle(30);
    total++; if (valid_cnt - v0 !== exp_q.size()) begin bad++; $display("FAIL rnd_valid_count got=%0d want=%0d", valid_cnt - v0, exp_q.size()); end
    total++; if (ferr_cnt - f0 !== exp_ferr) begin bad++; $display("FAIL rnd_ferr_count got=%0d want=%0d", ferr_cnt - f0, exp_ferr); end
`ifdef UART_RX_PARITY_EN
    total++; if (perr_cnt - p0 !== exp_perr) begin bad++; $display("FAIL rnd_perr_count got=%0d want=%0d", perr_cnt - p0, exp_perr); end
`endif
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      total++; if (got !== b) begin bad++; $display("FAIL rnd_byte got=%h want=%h", got, b); end
    end
    total++; if (bus.Output_Data !== exp_last) begin bad++; $display("FAIL rnd_last got=%h want=%h", bus.Output_Data, exp_last); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
  endtask

  initial begin
    bus.Serial_Data = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
